// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: zero-fills a single-port sync RAM and then
// shares it round-robin between two ready/valid requesters.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             in RUN: restart the zero-fill
//   init_done         high while accepting requests
//   a_/b_req,we,addr,wdata   request payload per port
//   a_/b_ready        request accepted this cycle
//   a_/b_rvalid,rdata read data, one cycle after accept
//   ram_address, ram_write_data, ram_write_en  to RAM
//   ram_read_data     from RAM, one cycle after address
module ram_port_arbiter #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  output logic            init_done,

  input  logic            a_req,
  output logic            a_ready,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [SIZE-1:0] a_wdata,
  output logic            a_rvalid,
  output logic [SIZE-1:0] a_rdata,

  input  logic            b_req,
  output logic            b_ready,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [SIZE-1:0] b_wdata,
  output logic            b_rvalid,
  output logic [SIZE-1:0] b_rdata,

  output logic [AW-1:0]   ram_address,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  input  logic [SIZE-1:0] ram_read_data
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR =
    AW'(DEPTH - 1);

  logic          state_q;
  logic          state_d;
  logic [AW-1:0] clr_addr_q;
  logic [AW-1:0] clr_addr_d;
  logic          last_q;
  logic          last_d;
  logic          rsp_valid_q;
  logic          rsp_valid_d;
  logic          rsp_sel_q;
  logic          rsp_sel_d;
  logic [AW-1:0] hold_addr_q;
  logic [AW-1:0] hold_addr_d;

  logic run;
  logic gnt_a;
  logic gnt_b;

  assign run = (state_q == ST_RUN);

  // On a tie the port that did not win last time goes.
  assign gnt_a = run & a_req &
    (~b_req | (last_q == PORT_B));
  assign gnt_b = run & b_req &
    (~a_req | (last_q == PORT_A));

  assign init_done = run;
  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;

  assign a_rvalid = rsp_valid_q &
    (rsp_sel_q == PORT_A);
  assign b_rvalid = rsp_valid_q &
    (rsp_sel_q == PORT_B);

  assign a_rdata = ram_read_data;
  assign b_rdata = ram_read_data;

  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    last_d         = last_q;
    rsp_valid_d    = 1'b0;
    rsp_sel_d      = rsp_sel_q;
    hold_addr_d    = hold_addr_q;
    ram_address    = hold_addr_q;
    ram_write_data = '0;
    ram_write_en   = 1'b0;

    unique case (1'b1)
      !run: begin
        ram_address    = clr_addr_q;
        ram_write_data = '0;
        ram_write_en   = 1'b1;
        hold_addr_d    = clr_addr_q;
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      gnt_a: begin
        ram_address    = a_addr;
        ram_write_data = a_wdata;
        ram_write_en   = a_we;
        hold_addr_d    = a_addr;
        last_d         = PORT_A;
        rsp_valid_d    = ~a_we;
        rsp_sel_d      = PORT_A;
      end
      gnt_b: begin
        ram_address    = b_addr;
        ram_write_data = b_wdata;
        ram_write_en   = b_we;
        hold_addr_d    = b_addr;
        last_d         = PORT_B;
        rsp_valid_d    = ~b_we;
        rsp_sel_d      = PORT_B;
      end
      default: begin
      end
    endcase

    // The transfer granted alongside clear still completes.
    if (run && clear) begin
      state_d    = ST_INIT;
      clr_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_addr_q  <= '0;
      last_q      <= PORT_B;
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= PORT_A;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sel_q   <= rsp_sel_d;
      hold_addr_q <= hold_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random and directed traffic against a
// reference model, read data checked through a scoreboard.
module tb_ram_port_arbiter;

  localparam int SIZE  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            init_done;
  logic            a_req, a_ready, a_we, a_rvalid;
  logic [AW-1:0]   a_addr;
  logic [SIZE-1:0] a_wdata, a_rdata;
  logic            b_req, b_ready, b_we, b_rvalid;
  logic [AW-1:0]   b_addr;
  logic [SIZE-1:0] b_wdata, b_rdata;
  logic [AW-1:0]   ram_address;
  logic [SIZE-1:0] ram_write_data;
  logic            ram_write_en;
  logic [SIZE-1:0] ram_read_data;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .SIZE (SIZE),
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .init_done     (init_done),
    .a_req         (a_req),
    .a_ready       (a_ready),
    .a_we          (a_we),
    .a_addr        (a_addr),
    .a_wdata       (a_wdata),
    .a_rvalid      (a_rvalid),
    .a_rdata       (a_rdata),
    .b_req         (b_req),
    .b_ready       (b_ready),
    .b_we          (b_we),
    .b_addr        (b_addr),
    .b_wdata       (b_wdata),
    .b_rvalid      (b_rvalid),
    .b_rdata       (b_rdata),
    .ram_address   (ram_address),
    .ram_write_data(ram_write_data),
    .ram_write_en  (ram_write_en),
    .ram_read_data (ram_read_data)
  );

  // Single-port synchronous RAM with registered read.
  logic [SIZE-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  typedef struct {
    logic            port;
    logic [SIZE-1:0] data;
    int              cyc;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [SIZE-1:0] ref_mem [DEPTH];
  int   init_left;
  logic who_last;
  logic a_acc;
  logic b_acc;

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic serve(logic port, logic we,
                       logic [AW-1:0] addr,
                       logic [SIZE-1:0] wd);
    exp_t e;
    cmp("acc_addr", ram_address, addr);
    cmp("acc_we", ram_write_en, we);
    if (we) begin
      cmp("acc_wdata", ram_write_data, wd);
      ref_mem[addr] = wd;
    end else begin
      e.port = port;
      e.data = ref_mem[addr];
      e.cyc  = cyc + 1;
      sbq.push_back(e);
    end
    who_last = port;
  endtask

  task automatic check();
    logic ga, gb;
    int   ia;
    if (init_left > 0) begin
      ia = DEPTH - init_left;
      cmp("init_done_lo", init_done, 0);
      cmp("init_ready", {a_ready, b_ready}, 0);
      cmp("init_we", ram_write_en, 1);
      cmp("init_addr", ram_address, ia);
      cmp("init_wdata", ram_write_data, 0);
      ref_mem[ia] = '0;
      init_left--;
      a_acc = 1'b0;
      b_acc = 1'b0;
    end else begin
      cmp("init_done_hi", init_done, 1);
      ga = a_req && (!b_req || who_last == 1'b1);
      gb = b_req && (!a_req || who_last == 1'b0);
      cmp("a_ready", a_ready, ga);
      cmp("b_ready", b_ready, gb);
      a_acc = ga;
      b_acc = gb;
      if (ga) serve(1'b0, a_we, a_addr, a_wdata);
      if (gb) serve(1'b1, b_we, b_addr, b_wdata);
      if (!ga && !gb) cmp("idle_we", ram_write_en, 0);
      if (clear) init_left = DEPTH;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    cmp("rst_init_done", init_done, 0);
    cmp("rst_ready", {a_ready, b_ready}, 0);
    cmp("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    init_left = DEPTH;
    who_last  = 1'b1;
    a_acc     = 1'b0;
    b_acc     = 1'b0;
  endtask

  task automatic drive(bit ar, bit aw, int aa, int ad,
                       bit br, bit bw, int ba, int bd,
                       bit clr);
    a_req   = ar;
    a_we    = aw;
    a_addr  = AW'(aa);
    a_wdata = SIZE'(ad);
    b_req   = br;
    b_we    = bw;
    b_addr  = AW'(ba);
    b_wdata = SIZE'(bd);
    clear   = clr;
  endtask

  // Scoreboard monitor: read data must arrive exactly one
  // cycle after acceptance, on the issuing port only.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_rvalid || b_rvalid) begin
        cmp("rv_onehot", a_rvalid && b_rvalid, 0);
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL rv_unexpected: got a=%0b b=%0b want none",
                   a_rvalid, b_rvalid);
        end else begin
          e = sbq.pop_front();
          cmp("rv_port", b_rvalid, e.port);
          cmp("rdata", e.port ? b_rdata : a_rdata, e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL rv_missing: got none want port %0b", e.port);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    init_left = DEPTH;
    who_last  = 1'b1;
    a_acc     = 1'b0;
    b_acc     = 1'b0;
    #3;
    do_reset();

    // Both ports held through zero-fill, then alternate.
    drive(1, 0, 1, 0, 1, 0, 2, 0, 0);
    repeat (22) step();

    // A alone reads every address.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, i, 0, 0, 0, 0, 0, 0);
      step();
    end

    // A writes 0xA5 to 3 while B keeps reading 3.
    drive(1, 1, 3, 'hA5, 1, 0, 3, 0, 0);
    repeat (8) step();

    // Write 5, clear, wait out zero-fill, read 5.
    drive(1, 1, 5, 'h3C, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH) step();
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    step();

    // Read accepted together with clear; clear in INIT ignored.
    drive(0, 0, 0, 0, 1, 1, 2, 'h77, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 2, 0, 1);
    step();
    drive(0, 0, 0, 0, 1, 0, 2, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 0, 1, 0, 2, 0, 1);
    step();
    drive(0, 0, 0, 0, 1, 0, 2, 0, 0);
    repeat (DEPTH - 2) step();

    // Reset in the middle of zero-fill at address 7.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) step();
    @(negedge clk);
    check();
    do_reset();
    repeat (DEPTH + 2) step();

    // Reset while an accepted read is in flight.
    drive(1, 0, 4, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 2) step();

    // Random traffic; unaccepted requests are held.
    for (int i = 0; i < 400; i++) begin
      if (!(a_req && !a_acc)) begin
        a_req   = ($urandom_range(0, 3) != 0);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = AW'($urandom_range(0, DEPTH - 1));
        a_wdata = SIZE'($urandom);
      end
      if (!(b_req && !b_acc)) begin
        b_req   = ($urandom_range(0, 3) != 0);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = AW'($urandom_range(0, DEPTH - 1));
        b_wdata = SIZE'($urandom);
      end
      clear = ($urandom_range(0, 59) == 0);
      step();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    cmp("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
